spi_mstr_param: RTL and testbench

SPI_MSTR_PARAM -- requirements
Module: spi_mstr_param

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sclk_gen.sv | 53 +++++
 rtl/spi_mstr_param.sv | 148 ++++++++++++++
 tb/tb_spi_mstr_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: controller states and the {CPOL,CPHA} mode word.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRONT = 2'd1,
      TRANS = 2'd2,
      BACK  = 2'd3
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } mode_t;

   localparam mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period timer, leading/trailing edge strobes and the SCLK level.
// Strobes are asserted in the cycle before SCLK changes, so data sampled on a strobe
// is captured on the same clk edge that moves SCLK.
module spi_sclk_gen #(
   parameter int SCLK_DIV = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic load_cpol,
   input  logic cpol,
   input  logic run,
   input  logic lead_ok,
   output logic half_tick,
   output logic lead_edge,
   output logic trail_edge,
   output logic sclk
);

   localparam int HALF = SCLK_DIV / 2;
   localparam int CW   = $clog2(SCLK_DIV);

   logic [CW-1:0] cnt;
   logic          active;

   assign half_tick  = run && (cnt == CW'(HALF - 1));
   assign lead_edge  = half_tick && !active && lead_ok;
   assign trail_edge = half_tick && active;

   // Half-period counter, restarted at each transfer start and each half period.
   always_ff @(posedge clk) begin
      if (rst || load || half_tick) cnt <= '0;
      else if (run)                 cnt <= cnt + 1'b1;
   end

   // SCLK level: idle at CPOL, opposite level during the leading phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         sclk   <= 1'b0;
      end else if (load) begin
         active <= 1'b0;
         sclk   <= load_cpol;
      end else if (lead_edge) begin
         active <= 1'b1;
         sclk   <= ~cpol;
      end else if (trail_edge) begin
         active <= 1'b0;
         sclk   <= cpol;
      end
   end

endmodule

// File: rtl/spi_mstr_param.sv
// Parameterised SPI master: one DATA_W-bit full-duplex transfer per accepted wrt,
// all four SPI modes, selectable bit order and slave select.
module spi_mstr_param
   import spi_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int SCLK_DIV = 64,
   parameter  int NUM_SS   = 1,
   localparam int SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrt,
   input  logic [DATA_W-1:0] cmd,
   input  logic [1:0]        mode,
   input  logic              lsb_first,
   input  logic [SEL_W-1:0]  ss_sel,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic [NUM_SS-1:0] SS_n,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data
);

   localparam int BW = $clog2(DATA_W + 1);

   state_t            state, state_nx;
   mode_t             mode_q;
   logic              lsb_q;
   logic [DATA_W-1:0] tx, rx;
   logic [BW-1:0]     bit_cnt;
   logic              acc, lead_ok, last_bit;
   logic              half_tick, lead_edge, trail_edge;

   // Active-low select pattern; anything out of range falls back to slave 0.
   function automatic logic [NUM_SS-1:0] sel_dec(input logic [SEL_W-1:0] s);
      logic [NUM_SS-1:0] m;
      m = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (int'(s) == i) m[i] = 1'b0;
      if (&m) m[0] = 1'b0;
      return m;
   endfunction

   function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? v[0] : v[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   // Received bits land so that rd_data ends up in natural order for either bit order.
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b,
                                                  input logic lsb);
      return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
   endfunction

   assign acc      = (state == IDLE) && wrt;
   assign busy     = (state != IDLE);
   assign lead_ok  = (state == FRONT) || ((state == TRANS) && (bit_cnt != BW'(DATA_W)));
   assign last_bit = (bit_cnt == BW'(DATA_W - 1));

   spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
      .clk        (clk),
      .rst        (rst),
      .load       (acc),
      .load_cpol  (mode[1]),
      .cpol       (mode_q.cpol),
      .run        (busy),
      .lead_ok    (lead_ok),
      .half_tick  (half_tick),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .sclk       (SCLK)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state: every phase advances on a half-period tick; TRANS ends on the tick
   // that would have been a leading edge once all bits are clocked.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (wrt) state_nx = FRONT;
         FRONT:   if (half_tick) state_nx = TRANS;
         TRANS:   if (half_tick && !lead_edge && !trail_edge) state_nx = BACK;
         BACK:    if (half_tick) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Transfer datapath: latch request, shift MOSI/MISO on SCLK edges, publish result.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= MODE0;
         lsb_q   <= 1'b0;
         tx      <= '0;
         rx      <= '0;
         bit_cnt <= '0;
         MOSI    <= 1'b0;
         SS_n    <= '1;
         done    <= 1'b0;
         rd_data <= '0;
      end else begin
         if (acc) begin
            mode_q  <= mode_t'(mode);
            lsb_q   <= lsb_first;
            tx      <= cmd;
            rx      <= '0;
            bit_cnt <= '0;
            SS_n    <= sel_dec(ss_sel);
            done    <= 1'b0;
            // CPHA=0 needs the first bit on the wire before the first leading edge.
            if (!mode[0]) MOSI <= out_bit(cmd, lsb_first);
         end
         if (lead_edge) begin
            if (mode_q.cpha) begin
               MOSI <= out_bit(tx, lsb_q);
               tx   <= shift_out(tx, lsb_q);
            end else begin
               rx   <= shift_in(rx, MISO, lsb_q);
            end
         end
         if (trail_edge) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (mode_q.cpha) begin
               rx <= shift_in(rx, MISO, lsb_q);
            end else if (!last_bit) begin
               MOSI <= out_bit(shift_out(tx, lsb_q), lsb_q);
               tx   <= shift_out(tx, lsb_q);
            end
         end
         if ((state == BACK) && half_tick) begin
            SS_n    <= '1;
            done    <= 1'b1;
            rd_data <= rx;
         end
      end
   end

endmodule

// File: tb/tb_spi_mstr_param.sv
// Scoreboard bench: stimulus pushes {rd_data, done cycle} expectations, monitors pop
// them when done rises. Instance A: 16-bit, /64, 4 selects. Instance B: 8-bit, /4.
module tb_spi_mstr_param;

   localparam int DW_A = 16, DIV_A = 64, NSS_A = 4;
   localparam int DW_B = 8,  DIV_B = 4;

   typedef struct {
      logic [31:0] data;
      int          at;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   // instance A signals
   logic              a_rst = 1'b1, a_wrt = 1'b0, a_lsb = 1'b0;
   logic [DW_A-1:0]   a_cmd = '0;
   logic [1:0]        a_mode = 2'b00, a_sel = 2'd0;
   logic              a_miso, a_sclk, a_mosi, a_busy, a_done;
   logic [NSS_A-1:0]  a_ss_n;
   logic [DW_A-1:0]   a_rd;

   // instance B signals
   logic              b_rst = 1'b1, b_wrt = 1'b0, b_lsb = 1'b0;
   logic [DW_B-1:0]   b_cmd = '0;
   logic [1:0]        b_mode = 2'b00;
   logic [0:0]        b_sel = 1'b0;
   logic              b_sclk, b_mosi, b_busy, b_done;
   logic [0:0]        b_ss_n;
   logic [DW_B-1:0]   b_rd;

   // slave model / observers
   bit                use_slave = 1'b0;
   logic [15:0]       slv_word = '0;
   logic              miso_s = 1'b0;
   int                slv_idx = 16;
   int                a_rise = 0;
   logic [15:0]       mosi_cap = '0;
   logic [1:0]        exp_sel = 2'd0;
   bit                ss_bad = 1'b0;
   logic              a_done_q = 1'b0, b_done_q = 1'b0;

   assign a_miso = use_slave ? miso_s : a_mosi;

   spi_mstr_param #(.DATA_W(DW_A), .SCLK_DIV(DIV_A), .NUM_SS(NSS_A)) dut_a (
      .clk(clk), .rst(a_rst), .wrt(a_wrt), .cmd(a_cmd), .mode(a_mode),
      .lsb_first(a_lsb), .ss_sel(a_sel), .MISO(a_miso), .SCLK(a_sclk),
      .MOSI(a_mosi), .SS_n(a_ss_n), .busy(a_busy), .done(a_done), .rd_data(a_rd)
   );

   spi_mstr_param #(.DATA_W(DW_B), .SCLK_DIV(DIV_B), .NUM_SS(1)) dut_b (
      .clk(clk), .rst(b_rst), .wrt(b_wrt), .cmd(b_cmd), .mode(b_mode),
      .lsb_first(b_lsb), .ss_sel(b_sel), .MISO(b_mosi), .SCLK(b_sclk),
      .MOSI(b_mosi), .SS_n(b_ss_n), .busy(b_busy), .done(b_done), .rd_data(b_rd)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Slave for the mode-3 test: new bit on each falling (leading) SCLK edge, LSB first.
   always @(posedge a_busy) slv_idx = 0;
   always @(negedge a_sclk) begin
      if (slv_idx < 16) begin
         miso_s = slv_word[slv_idx];
         slv_idx++;
      end
   end

   always @(posedge a_sclk) begin
      a_rise++;
      mosi_cap = {a_mosi, mosi_cap[15:1]};
   end

   // Monitor A: scoreboard pop on done rise, plus select-line sanity.
   always @(posedge clk) begin
      #1;
      if (a_ss_n !== 4'hF && a_ss_n !== ~(4'b0001 << exp_sel)) ss_bad = 1'b1;
      if (a_done && !a_done_q) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_done got=%0h want=none", a_rd);
         end else begin
            ea = qa.pop_front();
            chk("a_rd_data", 32'(a_rd), ea.data);
            chk("a_done_cycle", cyc, ea.at);
         end
      end
      a_done_q = a_done;
   end

   // Monitor B.
   always @(posedge clk) begin
      #1;
      if (b_done && !b_done_q) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_done got=%0h want=none", b_rd);
         end else begin
            eb = qb.pop_front();
            chk("b_rd_data", 32'(b_rd), eb.data);
            chk("b_done_cycle", cyc, eb.at);
         end
      end
      b_done_q = b_done;
   end

   // Issue a request on A at cycle T; returns at T+1.
   task automatic start_a(input logic [15:0] c, input logic [1:0] m, input logic lsb,
                          input logic [1:0] sel, input logic [15:0] exp, input bit push);
      a_cmd = c; a_mode = m; a_lsb = lsb; a_sel = sel; exp_sel = sel; a_wrt = 1'b1;
      if (push) qa.push_back('{data: 32'(exp), at: cyc + 1 + (DW_A + 1) * DIV_A});
      step();
      a_wrt = 1'b0;
   endtask

   task automatic pulse_a(input logic [15:0] c);
      a_cmd = c; a_mode = 2'b11; a_lsb = 1'b1; a_wrt = 1'b1;
      step();
      a_wrt = 1'b0;
   endtask

   task automatic wait_a_done(input int budget);
      int n = 0;
      while (!a_done && n < budget) begin step(); n++; end
      chk("a_done_within_budget", 32'(a_done), 32'd1);
   endtask

   task automatic wait_b_done(input int budget);
      int n = 0;
      while (!b_done && n < budget) begin step(); n++; end
      chk("b_done_within_budget", 32'(b_done), 32'd1);
   endtask

   initial begin
      // reset with wrt held high: must stay idle
      a_wrt = 1'b1;
      repeat (3) step();
      chk("rst_ss_n", 32'(a_ss_n), 32'hF);
      chk("rst_sclk", 32'(a_sclk), 32'd0);
      chk("rst_mosi", 32'(a_mosi), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_rd_data", 32'(a_rd), 32'd0);
      a_rst = 1'b0; a_wrt = 1'b0; b_rst = 1'b0;
      step();
      chk("wrt_with_rst_ignored", 32'(a_busy), 32'd0);

      // mode 0, MSB first, loopback, slave 2
      ss_bad = 1'b0; a_rise = 0;
      start_a(16'hA5C3, 2'b00, 1'b0, 2'd2, 16'hA5C3, 1'b1);
      chk("m0_t1_busy", 32'(a_busy), 32'd1);
      chk("m0_t1_ss_n", 32'(a_ss_n), 32'hB);
      chk("m0_t1_done", 32'(a_done), 32'd0);
      chk("m0_t1_mosi_msb", 32'(a_mosi), 32'd1);
      repeat (DIV_A / 2 - 1) step();
      chk("m0_sclk_before_lead", 32'(a_sclk), 32'd0);
      step();
      chk("m0_sclk_first_lead", 32'(a_sclk), 32'd1);
      wait_a_done(1200);
      chk("m0_sclk_rises", a_rise, 32'd16);
      chk("m0_ss_only_sel", 32'(ss_bad), 32'd0);

      // mode 3, LSB first, slave model returns 0x3C5A
      use_slave = 1'b1; slv_word = 16'h3C5A; ss_bad = 1'b0;
      step();
      start_a(16'h1234, 2'b11, 1'b1, 2'd1, 16'h3C5A, 1'b1);
      chk("m3_sclk_idle_high", 32'(a_sclk), 32'd1);
      chk("m3_ss_n", 32'(a_ss_n), 32'hD);
      wait_a_done(1200);
      chk("m3_sclk_idle_after", 32'(a_sclk), 32'd1);
      chk("m3_mosi_lsb_first", 32'(mosi_cap), 32'h1234);
      chk("m3_ss_only_sel", 32'(ss_bad), 32'd0);

      // wrt pulses in FRONT, TRANS, BACK are ignored
      use_slave = 1'b0; ss_bad = 1'b0;
      step();
      start_a(16'h5A0F, 2'b00, 1'b0, 2'd0, 16'h5A0F, 1'b1);
      repeat (9) step();
      pulse_a(16'hFFFF);
      repeat (489) step();
      pulse_a(16'h0000);
      repeat (569) step();
      pulse_a(16'h1111);
      wait_a_done(1200);
      repeat (40) step();
      chk("ign_busy_after", 32'(a_busy), 32'd0);
      chk("ign_done_holds", 32'(a_done), 32'd1);
      chk("ign_rd_holds", 32'(a_rd), 32'h5A0F);

      // reset in the middle of TRANS, then a clean transfer
      step();
      start_a(16'hC3C3, 2'b01, 1'b0, 2'd0, 16'h0, 1'b0);
      repeat (489) step();
      a_rst = 1'b1;
      step();
      a_rst = 1'b0;
      chk("mid_rst_ss_n", 32'(a_ss_n), 32'hF);
      chk("mid_rst_sclk", 32'(a_sclk), 32'd0);
      chk("mid_rst_mosi", 32'(a_mosi), 32'd0);
      chk("mid_rst_busy", 32'(a_busy), 32'd0);
      chk("mid_rst_done", 32'(a_done), 32'd0);
      chk("mid_rst_rd_data", 32'(a_rd), 32'd0);
      step();
      ss_bad = 1'b0;
      start_a(16'h0F0F, 2'b01, 1'b0, 2'd3, 16'h0F0F, 1'b1);
      chk("post_rst_ss_n", 32'(a_ss_n), 32'h7);
      wait_a_done(1200);
      chk("post_rst_ss_only_sel", 32'(ss_bad), 32'd0);

      // instance B: back-to-back transfers launched on done
      step();
      b_cmd = 8'h81; b_wrt = 1'b1;
      qb.push_back('{data: 32'h81, at: cyc + 1 + (DW_B + 1) * DIV_B});
      step();
      b_wrt = 1'b0;
      wait_b_done(60);
      chk("b2b_ss_high_on_done", 32'(b_ss_n), 32'd1);
      b_cmd = 8'h7E; b_wrt = 1'b1;
      qb.push_back('{data: 32'h7E, at: cyc + 1 + (DW_B + 1) * DIV_B});
      step();
      b_wrt = 1'b0;
      chk("b2b_ss_low", 32'(b_ss_n), 32'd0);
      chk("b2b_busy", 32'(b_busy), 32'd1);
      wait_b_done(60);

      repeat (5) step();
      chk("qa_drained", qa.size(), 32'd0);
      chk("qb_drained", qb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
